ibus_initiator: RTL
===================

Name: ibus_initiator

Overview:
- Single-outstanding IBUS master; the initiator end of the on-chip peripheral register bus.
- Converts a command port (address, data, size, direction) into one IBUS cycle:
  - drives address, write data, byte lanes, WE and REQ;
  - honours BUSY and ACT from responders;
  - returns lane-extracted, extended read data with an error code.
- Sits between CPU-side request logic or a debug/DMA engine and the shared IBUS responders (UBC, timers, cache/bus-state controllers).

Parameters:
- TO_CYCLES, 256, number of CE_R ticks an access may stay in ACCESS before a timeout is declared (2..65536).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset; synchronous, active-low
- CE_R  in  1  rising-phase clock enable; all state advances here
- CE_F  in  1  falling-phase clock enable; unused internally, passed for alignment with responders (responders update read data on CE_F)
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted when VALID&READY on a CE_R tick
- CMD_ADDR  in  32  byte address
- CMD_WDATA  in  32  write data, right-aligned
- CMD_SIZE  in  2  00 byte, 01 word, 10 long, 11 reserved
- CMD_WE  in  1  1 = write
- CMD_SIGNED  in  1  sign-extend read data (byte/word only)
- RSP_VALID  out  1  response valid, one CE_R period
- RSP_RDATA  out  32  extended read data; 0 on writes and on errors
- RSP_ERR  out  2  00 ok, 01 address error, 10 bus error (no ACT), 11 timeout
- IBUS_A  out  32  bus address
- IBUS_DO  out  32  bus write data, lane-replicated
- IBUS_DI  in  32  bus read data
- IBUS_BA  out  4  byte-lane enables; [3] = lane at A[1:0]=0 (big-endian)
- IBUS_WE  out  1  write strobe
- IBUS_REQ  out  1  request
- IBUS_BUSY  in  1  responder stall
- IBUS_ACT  in  1  OR of responder address-select

Behaviour:
- Reset:
  - When RST_N=0 at a CLK edge, independent of CE_R, all registers clear.
  - State = IDLE; CMD_READY=1; RSP_VALID=0; RSP_RDATA=0; RSP_ERR=00; IBUS_REQ=0; IBUS_WE=0; IBUS_BA=0000; IBUS_A=0; IBUS_DO=0.
  - Reset mid-access drops REQ on the same edge; no response is produced.
- Registered outputs: all update only on CE_R ticks (except reset).
- FSM state IDLE:
  - CMD_READY=1.
  - On VALID&READY, latch the command and check alignment:
    - SIZE=11 → address error.
    - Word with A[0]=1 → address error.
    - Long with A[1:0]≠00 → address error.
  - On address error → RESP with ERR=01; REQ never asserted.
  - Otherwise → ACCESS with REQ=1, WE=CMD_WE, A=CMD_ADDR; timeout counter cleared.
- Byte lanes:
  - byte → BA = 1000 >> A[1:0]
  - word → 1100 (A[1]=0) or 0011 (A[1]=1)
  - long → 1111
- Write data replication:
  - byte: {4{WDATA[7:0]}}
  - word: {2{WDATA[15:0]}}
  - long: WDATA
  - Held constant while REQ=1.
- FSM state ACCESS:
  - CMD_READY=0. REQ is held for at least one full CE_R period, so a CE_F tick always occurs with REQ high.
  - Completion on a CE_R tick with BUSY=0:
    - Sample ACT and IBUS_DI.
    - ACT=0 → ERR=10, RDATA=0.
    - Else ERR=00.
    - On reads, extract the selected lane(s) (byte lane = DI[31-8*A[1:0] -: 8]; word half = A[1]?DI[15:0]:DI[31:16]).
    - Zero- or sign-extend per CMD_SIGNED; long ignores SIGNED.
    - Drop REQ/WE, set BA=0000 → RESP.
  - BUSY=1: stay, increment counter.
- FSM state RESP:
  - RSP_VALID=1 for exactly one CE_R period.
  - Next CE_R tick → IDLE (VALID=0). RDATA/ERR hold until the next response.
- Throughput: minimum command acceptance to RSP_VALID is 2 CE_R ticks; back-to-back commands are spaced 3 CE_R ticks apart.
- Writes: RDATA forced to 0.
- CE_R low: everything frozen, including the timeout counter.

Optional Feature:
- IBUS_TIMEOUT_EN.
- Defined:
  - The counter increments on each CE_R tick in ACCESS with BUSY=1.
  - When it reaches TO_CYCLES-1 while BUSY is still 1 → drop REQ, ERR=11, RDATA=0, → RESP.
  - Completion and timeout on the same tick: completion wins.
- Undefined:
  - No counter logic; ACCESS waits indefinitely on BUSY.
  - ERR=11 is never produced.

Test Plan:
- Long write A=FFFFFF40, D=12345678, responder BUSY=0, ACT=1 → exactly one CE_R tick with REQ=1, BA=1111, DO=12345678, WE=1; RSP_VALID next tick, ERR=00, RDATA=0.
- Byte read A=FFFFFF42, SIGNED=1, responder DI=0011F233 → BA=0010, RSP_RDATA=FFFFFFF2; with SIGNED=0 → 000000F2.
- Word read A=FFFFFF7A, DI=AAAA8001, SIGNED=1 → BA=0011, RDATA=FFFF8001; word write A=..7A, WDATA=0000BEEF → DO=BEEFBEEF.
- Misaligned long A=FFFFFF42, or SIZE=11 → REQ never asserted, RSP_VALID next CE_R, ERR=01.
- Read A=00001000 with ACT=0, BUSY=0 → ERR=10, RDATA=0; BUSY held 3 ticks then released, ACT=1 → response exactly 3 ticks later than the no-wait case, with correct data.
- IBUS_TIMEOUT_EN, TO_CYCLES=8, BUSY stuck 1 → REQ drops after 8 ACCESS ticks, ERR=11; RST_N=0 mid-ACCESS → REQ=0 next CLK edge, no RSP_VALID.

Source files
------------

// File: rtl/ibus_initiator.sv
// rtl/ibus_initiator.sv - single-outstanding IBUS initiator (command port to one bus cycle)
//
// Purpose: accepts one command (address, data, size, direction), checks
// alignment, runs one IBUS cycle honouring BUSY/ACT and returns lane-extracted,
// zero/sign-extended read data with an error code.
//
// Optional feature macro: IBUS_TIMEOUT_EN (access timeout after TO_CYCLES
// busy ticks, reported as RSP_ERR=11). Undefined: ACCESS waits on BUSY forever.
//
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   CE_R, CE_F                 rising/falling clock enables (CE_F unused here)
//   CMD_VALID/READY            command handshake, taken on a CE_R tick
//   CMD_ADDR/WDATA/SIZE/WE/SIGNED  command fields
//   RSP_VALID/RDATA/ERR        one-CE_R-period response
//   IBUS_A/DO/BA/WE/REQ        bus drive
//   IBUS_DI/BUSY/ACT           bus return
module ibus_initiator #(
  parameter int TO_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [1:0]  CMD_SIZE,
  input  logic        CMD_WE,
  input  logic        CMD_SIGNED,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_BUS  = 2'b10;

  if (TO_CYCLES < 2 || TO_CYCLES > 65536) begin : g_bad_to_cycles
    $error("ibus_initiator: TO_CYCLES out of range 2..65536");
  end

  // Responders move read data on CE_F; this side only samples on CE_R.
  logic unused_ce_f;
  assign unused_ce_f = CE_F;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] do_q, do_d;
  logic [3:0]  ba_q, ba_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
`ifdef IBUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  localparam logic [15:0] CNT_LAST = 16'(TO_CYCLES - 1);
`endif

  // Alignment check, lane enables and write-data replication for the
  // command currently presented.
  logic        cmd_addr_err;
  logic [3:0]  cmd_ba;
  logic [31:0] cmd_do;

  always_comb begin
    cmd_addr_err = 1'b0;
    cmd_ba       = 4'b0000;
    cmd_do       = CMD_WDATA;
    case (CMD_SIZE)
      SZ_BYTE: begin
        cmd_ba = 4'b1000 >> CMD_ADDR[1:0];
        cmd_do = {4{CMD_WDATA[7:0]}};
      end
      SZ_WORD: begin
        cmd_addr_err = CMD_ADDR[0];
        cmd_ba       = CMD_ADDR[1] ? 4'b0011 : 4'b1100;
        cmd_do       = {2{CMD_WDATA[15:0]}};
      end
      SZ_LONG: begin
        cmd_addr_err = (CMD_ADDR[1:0] != 2'b00);
        cmd_ba       = 4'b1111;
      end
      default: cmd_addr_err = 1'b1;
    endcase
  end

  // Read lane extraction; big-endian, so A[1:0]=0 selects DI[31:24].
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] rd_ext;

  always_comb begin
    case (a_q[1:0])
      2'd0:    lane_b = IBUS_DI[31:24];
      2'd1:    lane_b = IBUS_DI[23:16];
      2'd2:    lane_b = IBUS_DI[15:8];
      default: lane_b = IBUS_DI[7:0];
    endcase
    lane_h = a_q[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
    case (size_q)
      SZ_BYTE: rd_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      SZ_WORD: rd_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: rd_ext = IBUS_DI;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    do_d        = do_q;
    ba_d        = ba_q;
    we_d        = we_q;
    req_d       = req_q;
    size_d      = size_q;
    signed_d    = signed_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef IBUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    if (CE_R) begin
      case (state_q)
        ST_IDLE: begin
          if (CMD_VALID) begin
            size_d   = CMD_SIZE;
            signed_d = CMD_SIGNED;
            if (cmd_addr_err) begin
              // Rejected before the bus is touched.
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = ERR_ADDR;
              rsp_rdata_d = 32'h0;
            end else begin
              state_d = ST_ACCESS;
              a_d     = CMD_ADDR;
              do_d    = cmd_do;
              ba_d    = cmd_ba;
              we_d    = CMD_WE;
              req_d   = 1'b1;
`ifdef IBUS_TIMEOUT_EN
              cnt_d   = 16'd0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (!IBUS_BUSY) begin
            // Completion has priority over a timeout on the same tick.
            state_d     = ST_RESP;
            req_d       = 1'b0;
            we_d        = 1'b0;
            ba_d        = 4'b0000;
            rsp_valid_d = 1'b1;
            if (!IBUS_ACT) begin
              rsp_err_d   = ERR_BUS;
              rsp_rdata_d = 32'h0;
            end else begin
              rsp_err_d   = ERR_OK;
              rsp_rdata_d = we_q ? 32'h0 : rd_ext;
            end
          end
`ifdef IBUS_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_d     = ST_RESP;
            req_d       = 1'b0;
            we_d        = 1'b0;
            ba_d        = 4'b0000;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 2'b11;
            rsp_rdata_d = 32'h0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      a_q         <= 32'h0;
      do_q        <= 32'h0;
      ba_q        <= 4'b0000;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 2'b00;
`ifdef IBUS_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      do_q        <= do_d;
      ba_q        <= ba_d;
      we_q        <= we_d;
      req_q       <= req_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef IBUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign IBUS_A    = a_q;
  assign IBUS_DO   = do_q;
  assign IBUS_BA   = ba_q;
  assign IBUS_WE   = we_q;
  assign IBUS_REQ  = req_q;

endmodule
